// File: rtl/score_bcd_converter_pkg.sv
// Shared types and constants for the score binary-to-BCD converter.
// The FSM state encoding and the add-3 correction constants live here.
package score_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [3:0] ADD3_OFFSET    = 4'd3;

endpackage

// File: rtl/score_bcd_converter_if.sv
// Request/result bundle between the score read port, the converter and the display driver.
// master drives Start/BinIn, slave (the converter) returns the BCD result.
interface score_bcd_converter_if #(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
);
    logic                  Start;
    logic [WIDTH-1:0]      BinIn;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   Bcd;
    logic [DIGITS-1:0]     DigitValid;
    logic                  Overflow;

    modport master (
        output Start, BinIn,
        input  Busy, Done, Bcd, DigitValid, Overflow
    );

    modport slave (
        input  Start, BinIn,
        output Busy, Done, Bcd, DigitValid, Overflow
    );
endinterface

// File: rtl/score_bcd_converter_bcd_add3_digit.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 before the next shift,
// so that the shift carries it correctly into the next decimal place.
module bcd_add3_digit
    import score_bcd_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digitIn,
    output logic [BCD_DIGIT_W-1:0] digitOut
);

    // Conditional +3 correction of one BCD scratch nibble
    always_comb begin
        digitOut = digitIn;
        if (digitIn >= ADD3_THRESHOLD) begin
            digitOut = digitIn + ADD3_OFFSET;
        end else begin
            digitOut = digitIn;
        end
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative shift-add-3 converter turning a latched binary reaction score into BCD digits
// plus a leading-zero mask; the display outputs only change when a conversion completes.
module score_bcd_converter
    import score_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
)(
    input  logic                 Clock,
    input  logic                 Reset,
    score_bcd_converter_if.slave bus
);

    localparam int SCR_W = (DIGITS + 1) * BCD_DIGIT_W;
    localparam int OUT_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t                 state_r;
    logic [WIDTH-1:0]       shiftReg_r;
    logic [SCR_W-1:0]       scratch_r;
    logic [SCR_W-1:0]       adj_s;
    logic [CNT_W-1:0]       count_r;
    logic                   lostBit_r;
    logic                   busy_r;
    logic                   done_r;
    logic [OUT_W-1:0]       bcd_r;
    logic [DIGITS-1:0]      digitValid_r;
    logic                   overflow_r;

    // Bit i set when digit i or any more significant digit is nonzero; units digit always shown
    function automatic logic [DIGITS-1:0] leadMask(input logic [OUT_W-1:0] digits);
        logic              seen;
        logic [DIGITS-1:0] m;
        seen = 1'b0;
        m    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (digits[i*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    // The guard nibble (index DIGITS) catches values beyond the displayable range
    for (genvar g = 0; g < DIGITS + 1; g++) begin : gen_add3
        bcd_add3_digit u_add3 (
            .digitIn  (scratch_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digitOut (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Conversion FSM with registered handshake and display outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r      <= IDLE;
            shiftReg_r   <= '0;
            scratch_r    <= '0;
            count_r      <= '0;
            lostBit_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            bcd_r        <= '0;
            digitValid_r <= {{(DIGITS-1){1'b0}}, 1'b1};
            overflow_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.Start) begin
                        shiftReg_r <= bus.BinIn;
                        scratch_r  <= '0;
                        lostBit_r  <= 1'b0;
                        count_r    <= CNT_W'(WIDTH);
                        busy_r     <= 1'b1;
                        state_r    <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch_r  <= {adj_s[SCR_W-2:0], shiftReg_r[WIDTH-1]};
                    shiftReg_r <= {shiftReg_r[WIDTH-2:0], 1'b0};
                    // A bit shifted out of the guard nibble still means the result was truncated
                    lostBit_r  <= lostBit_r | adj_s[SCR_W-1];
                    count_r    <= count_r - CNT_W'(1);
                    if (count_r == CNT_W'(1)) begin
                        state_r <= FINISH;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                FINISH: begin
                    bcd_r        <= scratch_r[OUT_W-1:0];
                    overflow_r   <= (scratch_r[SCR_W-1 -: BCD_DIGIT_W] != 4'd0) | lostBit_r;
                    digitValid_r <= leadMask(scratch_r[OUT_W-1:0]);
                    done_r       <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy       = busy_r;
    assign bus.Done       = done_r;
    assign bus.Bcd        = bcd_r;
    assign bus.DigitValid = digitValid_r;
    assign bus.Overflow   = overflow_r;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: a vector table for single conversions plus
// hand-written sequences for held Start, mid-conversion reset and a wider-input instance.
module tb_score_bcd_converter;

    logic Clock;
    logic Reset;
    int   compared;
    int   mismatched;
    logic [15:0] lastBcd;

    score_bcd_converter_if #(.WIDTH(13), .DIGITS(4)) bus ();
    score_bcd_converter_if #(.WIDTH(14), .DIGITS(4)) bus14 ();

    score_bcd_converter #(.WIDTH(13), .DIGITS(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    score_bcd_converter #(.WIDTH(14), .DIGITS(4)) dut14 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus14)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [12:0] binIn;
        logic [15:0] expBcd;
        logic [3:0]  expDv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One conversion on the 13-bit instance: checks latency, result and hold behaviour
    task automatic convert(input logic [12:0] v, input logic [15:0] expBcd, input logic [3:0] expDv);
        int lat;
        bit seen;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.BinIn = v;
        @(posedge Clock);
        #1 bus.Start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge Clock);
            #1;
            lat++;
            if (bus.Done) begin
                seen = 1'b1;
            end else if (lat == 5) begin
                check("busy_mid", {31'd0, bus.Busy}, 32'd1);
                check("bcd_held", {16'd0, bus.Bcd}, {16'd0, lastBcd});
            end
        end
        check("latency", lat, 14);
        check("bcd", {16'd0, bus.Bcd}, {16'd0, expBcd});
        check("digitValid", {28'd0, bus.DigitValid}, {28'd0, expDv});
        check("overflow", {31'd0, bus.Overflow}, 32'd0);
        lastBcd = expBcd;
        @(posedge Clock);
        #1;
        check("done_pulse", {31'd0, bus.Done}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int doneCount;
        bit seen;
        compared   = 0;
        mismatched = 0;
        lastBcd    = 16'h0000;

        vecs[0] = '{13'd0,    16'h0000, 4'b0001};
        vecs[1] = '{13'd8191, 16'h8191, 4'b1111};
        vecs[2] = '{13'd305,  16'h0305, 4'b0111};
        vecs[3] = '{13'd7,    16'h0007, 4'b0001};
        vecs[4] = '{13'd10,   16'h0010, 4'b0011};
        vecs[5] = '{13'd100,  16'h0100, 4'b0111};
        vecs[6] = '{13'd1000, 16'h1000, 4'b1111};
        vecs[7] = '{13'd9,    16'h0009, 4'b0001};
        vecs[8] = '{13'd4096, 16'h4096, 4'b1111};
        vecs[9] = '{13'd5959, 16'h5959, 4'b1111};

        bus.Start   = 1'b0;
        bus.BinIn   = 13'd0;
        bus14.Start = 1'b0;
        bus14.BinIn = 14'd0;
        Reset       = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_done", {31'd0, bus.Done}, 32'd0);
        check("rst_bcd", {16'd0, bus.Bcd}, 32'd0);
        check("rst_dv", {28'd0, bus.DigitValid}, 32'd1);
        check("rst_ovf", {31'd0, bus.Overflow}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].binIn, vecs[i].expBcd, vecs[i].expDv);
        end

        // Start held high; BinIn changes mid-conversion and must not disturb it
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.BinIn = 13'd1234;
        @(posedge Clock);
        #1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (lat == 2) bus.BinIn = 13'd999;
            @(posedge Clock);
            #1;
            lat++;
            seen = bus.Done;
        end
        check("held_latency1", lat, 14);
        check("held_bcd1", {16'd0, bus.Bcd}, 32'h1234);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge Clock);
            #1;
            lat++;
            seen = bus.Done;
            if (lat == 1) bus.Start = 1'b0;
        end
        check("held_latency2", lat, 15);
        check("held_bcd2", {16'd0, bus.Bcd}, 32'h0999);
        check("held_dv2", {28'd0, bus.DigitValid}, 32'h7);
        lastBcd = 16'h0999;
        @(posedge Clock);
        #1;
        check("held_idle", {31'd0, bus.Busy}, 32'd0);

        // Reset in the middle of a conversion aborts it without a Done pulse
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.BinIn = 13'd4321;
        @(posedge Clock);
        #1 bus.Start = 1'b0;
        repeat (5) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("abort_busy", {31'd0, bus.Busy}, 32'd0);
        check("abort_bcd", {16'd0, bus.Bcd}, 32'd0);
        check("abort_dv", {28'd0, bus.DigitValid}, 32'd1);
        @(negedge Clock);
        Reset = 1'b0;
        doneCount = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clock);
            #1;
            if (bus.Done) doneCount++;
        end
        check("abort_no_done", doneCount, 0);
        lastBcd = 16'h0000;
        convert(13'd4321, 16'h4321, 4'b1111);

        // 14-bit instance: values beyond 9999 set Overflow and keep the low four digits
        for (int k = 0; k < 3; k++) begin
            logic [13:0] v14;
            logic [15:0] eb;
            logic        eo;
            v14 = (k == 0) ? 14'd12000 : (k == 1) ? 14'd16383 : 14'd9999;
            eb  = (k == 0) ? 16'h2000  : (k == 1) ? 16'h6383  : 16'h9999;
            eo  = (k == 2) ? 1'b0 : 1'b1;
            @(negedge Clock);
            bus14.Start = 1'b1;
            bus14.BinIn = v14;
            @(posedge Clock);
            #1 bus14.Start = 1'b0;
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 40) begin
                @(posedge Clock);
                #1;
                lat++;
                seen = bus14.Done;
            end
            check("w14_latency", lat, 15);
            check("w14_bcd", {16'd0, bus14.Bcd}, {16'd0, eb});
            check("w14_ovf", {31'd0, bus14.Overflow}, {31'd0, eo});
            check("w14_dv", {28'd0, bus14.DigitValid}, 32'hF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
- Sequential binary-to-BCD converter (iterative shift-add-3 / double dabble) between the register file read port (13-bit reaction score, DATAQ) and the per-digit seven-segment decoders.
- Converts one latched binary score into four decimal digits so the score screens show base-10 milliseconds instead of hex nibbles.
- Also produces a per-digit leading-zero mask so the display driver can blank leading zeros.

Parameters:
- WIDTH, 13, bit width of binary input (max score 8191).
- DIGITS, 4, number of BCD output digits; 10^DIGITS-1 must be >= 2^WIDTH-1 for Overflow to stay 0.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request conversion of BinIn; sampled only when not Busy.
- BinIn  input  WIDTH  binary value to convert (score from register file read port Q).
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when Bcd/DigitValid have been updated.
- Bcd  output  4*DIGITS  packed BCD result, digit 0 = Bcd[3:0] (rightmost screen); held until next Done.
- DigitValid  output  DIGITS  bit i = 1 if digit i is significant (not a leading zero); bit 0 always 1.
- Overflow  output  1  latched with Bcd: 1 if the input exceeded 10^DIGITS-1 (result truncated).

Behaviour:
- Reset (sync, active-high, overrides everything incl. Start): state=IDLE, Busy=0, Done=0, Bcd=0, DigitValid=1 (bit 0 only), Overflow=0, internal shift count=0.
- States: IDLE, SHIFT, FINISH.
- IDLE: Start=1 -> latch BinIn into shift register, clear BCD scratch (DIGITS+1 nibbles incl. overflow guard nibble), count=WIDTH, go SHIFT. Start=0 -> stay.
- SHIFT: each cycle, every scratch nibble >=5 gets +3, then the {scratch, shift} vector shifts left by 1; count decrements. When count reaches 1 on entry to the cycle (last shift), go FINISH. Exactly WIDTH cycles in SHIFT.
- FINISH (one cycle): Bcd <= lower DIGITS scratch nibbles; Overflow <= (guard nibble != 0); DigitValid[i] <= any digit j>=i nonzero, bit 0 forced 1; Done=1 in this cycle only; go IDLE.
- Busy=1 in SHIFT and FINISH states, 0 in IDLE. Start while Busy=1 is ignored (not queued).
- Latency: Start sampled at edge N -> Done high during cycle N+WIDTH+1 (14 cycles for default); Bcd valid from that same cycle. Next Start accepted the cycle after Done (throughput one conversion per WIDTH+2 cycles).
- BinIn is sampled only at Start acceptance; later changes have no effect on the current conversion.
- Outputs Bcd/DigitValid/Overflow change only in FINISH or Reset; stable otherwise (no glitching mid-conversion, display stays on old value).
- Reset mid-conversion: abort, all outputs to reset values, no Done pulse.
- Input 0 -> Bcd all zero, DigitValid=0001.

Decomposition:
- Shared package: state encoding constants (IDLE/SHIFT/FINISH), BCD_DIGIT_W=4, ADD3_THRESHOLD=5.
- One natural sub-module: bcd_add3_digit (combinational 4-bit nibble correction: out = in>=5 ? in+3 : in), instantiated DIGITS+1 times via generate.

Test Plan:
- Reset, then Start with BinIn=0 -> Done at cycle 14, Bcd=16'h0000, DigitValid=4'b0001, Overflow=0.
- BinIn=8191 (13'h1FFF), Start -> Done exactly 14 cycles after Start, Bcd=16'h8191, DigitValid=4'b1111, Overflow=0.
- BinIn=305 -> Bcd=16'h0305, DigitValid=4'b0111; then BinIn=7 -> Bcd=16'h0007, DigitValid=4'b0001; old Bcd held until second Done.
- Start held high continuously with BinIn=1234, BinIn changed to 999 at cycle 3 -> first Done gives 16'h1234, Busy ignores repeats, next conversion starts cycle after Done and yields 16'h0999.
- Start BinIn=4321, assert Reset at cycle 6 -> no Done pulse, Busy=0, Bcd=0 next cycle; new Start afterwards converts correctly.
- Parameter override WIDTH=14, DIGITS=4, BinIn=12000 -> Overflow=1, Bcd=16'h2000.
